// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: program-loader state encoding, header size and the
// instruction-memory write payload.
package rv32i_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned LOADER_HDR_BYTES = 4;
    localparam int unsigned LOADER_IDX_W     = 16;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HEADER,
        LD_DATA,
        LD_WRITE,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } imem_wr_t;

endpackage

// File: rtl/rv32i_byte_word_assembler.sv
// Little-endian byte-to-word assembler: four loads fill a 32-bit word, with the
// completed word visible combinationally on the cycle of the fourth byte.
module rv32i_byte_word_assembler
    import rv32i_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic [7:0]      i_byte,
    output logic [XLEN-1:0] o_word_next_c,
    output logic            o_word_complete_c
);

    logic [1:0]      r_cnt;
    logic [XLEN-1:0] r_word;

    // Bytes enter at the top and shift down, so byte k ends up in bits [8k+7:8k].
    assign o_word_next_c     = {i_byte, r_word[XLEN-1:8]};
    assign o_word_complete_c = i_load && (r_cnt == 2'(LOADER_HDR_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt  <= 2'd0;
            r_word <= '0;
        end else if (i_load) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= o_word_next_c;
        end
    end

endmodule

// File: rtl/rv32i_program_loader.sv
// Byte-stream program loader: reads a word-count header, then writes each
// assembled word into instruction memory while holding the core in reset.
module rv32i_program_loader
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter logic [15:0] MAX_WORDS  = 16'd1024,
    parameter logic [15:0] WR_TIMEOUT = 16'd255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic        o_instruction_wr_en,
    output logic [31:0] o_instruction_wr_addr,
    output logic [31:0] o_instruction_wr_data,
    input  logic        i_instruction_wr_valid,
    output logic        o_core_rst,
    output logic        o_load_busy,
    output logic        o_load_done,
    output logic        o_load_error
);

    localparam logic [31:0] BASE_ALIGNED = {BASE_ADDR[31:2], 2'b00};

    loader_state_t            r_state;
    loader_state_t            w_next;
    logic [LOADER_IDX_W-1:0]  r_idx;
    logic [LOADER_IDX_W-1:0]  r_count;
    logic [LOADER_IDX_W-1:0]  r_to;
    imem_wr_t                 r_wr;
    logic                     r_byte_ready;
    logic                     r_wr_en;
    logic                     r_core_rst;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;

    logic                     w_fire;
    logic                     w_asm_load;
    logic                     w_asm_clear;
    logic                     w_word_done;
    logic                     w_wr_ack;
    logic [XLEN-1:0]          w_word_next;

    rv32i_byte_word_assembler u_asm (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_clear           (w_asm_clear),
        .i_load            (w_asm_load),
        .i_byte            (i_byte_data),
        .o_word_next_c     (w_word_next),
        .o_word_complete_c (w_word_done)
    );

    // o_byte_ready is registered from the next state, so it is high exactly in HEADER/DATA.
    assign w_fire   = i_byte_valid && r_byte_ready;
    assign w_wr_ack = (r_state == LD_WRITE) && i_instruction_wr_valid;

    // Next-state and assembler control.
    always_comb begin
        w_next      = r_state;
        w_asm_load  = 1'b0;
        w_asm_clear = 1'b0;
        case (r_state)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (i_load_start) begin
                    w_next      = LD_HEADER;
                    w_asm_clear = 1'b1;
                end
            end
            LD_HEADER: begin
                w_asm_load = w_fire;
                if (w_word_done) begin
                    if ((w_word_next[31:16] != 16'd0) || (w_word_next[15:0] > MAX_WORDS))
                        w_next = LD_ERROR;
                    else if (w_word_next[15:0] == 16'd0)
                        w_next = LD_DONE;
                    else
                        w_next = LD_DATA;
                end
            end
            LD_DATA: begin
                w_asm_load = w_fire;
                if (w_word_done)
                    w_next = LD_WRITE;
            end
            LD_WRITE: begin
                if (w_wr_ack)
                    w_next = ((r_idx + 16'd1) == r_count) ? LD_DONE : LD_DATA;
                else if ((r_to + 16'd1) == WR_TIMEOUT)
                    w_next = LD_ERROR;
            end
            default: w_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= LD_IDLE;
            r_idx        <= '0;
            r_count      <= '0;
            r_to         <= '0;
            r_wr         <= '0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_core_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == LD_HEADER) || (w_next == LD_DATA);
            r_wr_en      <= (w_next == LD_WRITE);
            r_busy       <= (w_next == LD_HEADER) || (w_next == LD_DATA) || (w_next == LD_WRITE);
            r_core_rst   <= (w_next != LD_IDLE) && (w_next != LD_DONE);

            if (w_asm_clear) begin
                r_idx   <= '0;
                r_count <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
            if ((w_next == LD_DONE) && (r_state != LD_DONE))
                r_done <= 1'b1;
            if ((w_next == LD_ERROR) && (r_state != LD_ERROR))
                r_error <= 1'b1;

            if ((r_state == LD_HEADER) && w_word_done)
                r_count <= w_word_next[15:0];

            // Address and data latch once on WRITE entry and stay put until the ack.
            if ((r_state == LD_DATA) && w_word_done) begin
                r_wr.addr <= BASE_ALIGNED + (32'(r_idx) << 2);
                r_wr.data <= w_word_next;
                r_to      <= '0;
            end

            if (r_state == LD_WRITE) begin
                if (w_wr_ack) begin
                    r_idx <= r_idx + 16'd1;
                    r_to  <= '0;
                end else begin
                    r_to  <= r_to + 16'd1;
                end
            end
        end
    end

    assign o_byte_ready          = r_byte_ready;
    assign o_instruction_wr_en   = r_wr_en;
    assign o_instruction_wr_addr = r_wr.addr;
    assign o_instruction_wr_data = r_wr.data;
    assign o_core_rst            = r_core_rst;
    assign o_load_busy           = r_busy;
    assign o_load_done           = r_done;
    assign o_load_error          = r_error;

endmodule

// File: tb/tb_rv32i_program_loader.sv
// Self-checking bench for rv32i_program_loader: table-driven loads, hand-written
// corner sequences and randomized loads against a transaction-level model.
module tb_rv32i_program_loader;

    localparam logic [31:0] TB_BASE = 32'h0000_1002;
    localparam logic [15:0] TB_MAX  = 16'd4;
    localparam logic [15:0] TB_TO   = 16'd12;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_load_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte_data = 8'h00;
    logic        o_byte_ready;
    logic        o_instruction_wr_en;
    logic [31:0] o_instruction_wr_addr;
    logic [31:0] o_instruction_wr_data;
    logic        i_instruction_wr_valid = 1'b0;
    logic        o_core_rst;
    logic        o_load_busy;
    logic        o_load_done;
    logic        o_load_error;

    rv32i_program_loader #(
        .BASE_ADDR  (TB_BASE),
        .MAX_WORDS  (TB_MAX),
        .WR_TIMEOUT (TB_TO)
    ) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_load_start           (i_load_start),
        .i_byte_valid           (i_byte_valid),
        .i_byte_data            (i_byte_data),
        .o_byte_ready           (o_byte_ready),
        .o_instruction_wr_en    (o_instruction_wr_en),
        .o_instruction_wr_addr  (o_instruction_wr_addr),
        .o_instruction_wr_data  (o_instruction_wr_data),
        .i_instruction_wr_valid (i_instruction_wr_valid),
        .o_core_rst             (o_core_rst),
        .o_load_busy            (o_load_busy),
        .o_load_done            (o_load_done),
        .o_load_error           (o_load_error)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write-port responder and monitor, shared state with the main sequence.
    bit          ack_en    = 1'b1;
    bit          ack_rnd   = 1'b0;
    bit          noise     = 1'b0;
    bit          gaps_on   = 1'b0;
    int          ack_delay = 0;
    int          wcnt      = 0;
    int          cur_len   = 0;
    int          last_len  = 0;
    int          wr_pulses = 0;
    bit          prev_en   = 1'b0;
    logic [31:0] cap_addr, cap_data;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] tx_words[$];

    initial begin
        forever begin
            @(negedge i_clk);
            i_instruction_wr_valid = 1'b0;
            if (o_instruction_wr_en) begin
                if (!prev_en) begin
                    cap_addr = o_instruction_wr_addr;
                    cap_data = o_instruction_wr_data;
                    cur_len  = 0;
                    wr_pulses++;
                end else begin
                    chk("wr_addr_stable", o_instruction_wr_addr, cap_addr);
                    chk("wr_data_stable", o_instruction_wr_data, cap_data);
                end
                cur_len++;
                last_len = cur_len;
                if (ack_en && wcnt >= ack_delay) begin
                    i_instruction_wr_valid = 1'b1;
                    got_addr.push_back(cap_addr);
                    got_data.push_back(cap_data);
                    wcnt = 0;
                    if (ack_rnd) ack_delay = $urandom_range(0, 3);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (noise && $urandom_range(0, 5) == 0) i_instruction_wr_valid = 1'b1;
            end
            prev_en = o_instruction_wr_en;
        end
    end

    task automatic bound_fail(input string name, input int n);
        checks++;
        errors++;
        $display("FAIL %s: no progress after %0d cycles", name, n);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (gaps_on) repeat ($urandom_range(0, 2)) @(negedge i_clk);
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        while (!o_byte_ready && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 300) bound_fail("byte_accept", n);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hFF));
    endtask

    task automatic start_pulse(input bit with_byte);
        i_load_start = 1'b1;
        if (with_byte) begin
            i_byte_valid = 1'b1;
            i_byte_data  = 8'hA5;
        end
        @(negedge i_clk);
        i_load_start = 1'b0;
        i_byte_valid = 1'b0;
        chk("start_byte_ready", 32'(o_byte_ready), 32'd1);
        chk("start_busy", 32'(o_load_busy), 32'd1);
        chk("start_core_rst", 32'(o_core_rst), 32'd1);
        chk("start_clears_done", 32'(o_load_done), 32'd0);
    endtask

    task automatic fill_random(input int n);
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back($urandom);
    endtask

    // Model: a header within limits yields count writes at base+4i with the sent words.
    task automatic run_load(input logic [31:0] hdr, input bit with_byte, input bit mid_start,
                            output int n_got);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        bit ok;
        int n;
        int t;
        got_addr.delete();
        got_data.delete();
        wr_pulses = 0;
        ok = (hdr[31:16] == 16'd0) && (hdr[15:0] <= TB_MAX);
        n  = ok ? int'(hdr[15:0]) : 0;
        for (int i = 0; i < n; i++) begin
            exp_a.push_back((TB_BASE & ~32'h3) + 32'(4 * i));
            exp_d.push_back(tx_words[i]);
        end
        start_pulse(with_byte);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'((hdr >> (8 * k)) & 32'hFF));
            if (mid_start && k == 1) begin
                i_load_start = 1'b1;
                @(negedge i_clk);
                i_load_start = 1'b0;
            end
        end
        for (int i = 0; i < n; i++) send_word(tx_words[i]);
        t = 0;
        while (o_load_busy && t < 400) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 400) bound_fail("load_finish", t);
        chk("end_core_rst", 32'(o_core_rst), 32'(!ok));
        chk("end_byte_ready", 32'(o_byte_ready), 32'd0);
        chk("end_wr_en", 32'(o_instruction_wr_en), 32'd0);
        chk("wr_pulses", 32'(wr_pulses), 32'(n));
        chk("write_count", 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            chk("write_addr", got_addr[i], exp_a[i]);
            chk("write_data", got_data[i], exp_d[i]);
        end
        n_got = got_addr.size();
    endtask

    typedef struct {
        logic [31:0] hdr;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nw;
        int t;
        logic [31:0] hdr;

        vecs[0] = '{32'd2,          1'b1, 1'b0, 2};
        vecs[1] = '{32'd0,          1'b1, 1'b0, 0};
        vecs[2] = '{32'd5,          1'b0, 1'b1, 0};
        vecs[3] = '{32'd4,          1'b1, 1'b0, 4};
        vecs[4] = '{32'h0001_0001,  1'b0, 1'b1, 0};
        vecs[5] = '{32'd1,          1'b1, 1'b0, 1};

        repeat (3) @(negedge i_clk);
        chk("rst_byte_ready", 32'(o_byte_ready), 32'd0);
        chk("rst_wr_en", 32'(o_instruction_wr_en), 32'd0);
        chk("rst_wr_addr", o_instruction_wr_addr, 32'd0);
        chk("rst_wr_data", o_instruction_wr_data, 32'd0);
        chk("rst_core_rst", 32'(o_core_rst), 32'd0);
        chk("rst_busy", 32'(o_load_busy), 32'd0);
        chk("rst_done", 32'(o_load_done), 32'd0);
        chk("rst_error", 32'(o_load_error), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Known program: gap-free, then with random byte gaps, same writes expected.
        for (int pass = 0; pass < 2; pass++) begin
            gaps_on = (pass == 1);
            tx_words.delete();
            tx_words.push_back(32'h0000_0013);
            tx_words.push_back(32'h0010_0093);
            run_load(32'd2, 1'b0, 1'b0, nw);
            chk("prog_done", 32'(o_load_done), 32'd1);
            chk("prog_first_addr", (nw > 0) ? got_addr[0] : 32'hDEAD_BEEF, 32'h0000_1000);
        end

        // Table of headers with fixed outcomes.
        gaps_on = 1'b0;
        for (int v = 0; v < 6; v++) begin
            fill_random(vecs[v].exp_writes);
            run_load(vecs[v].hdr, 1'b0, 1'b0, nw);
            chk("tbl_done", 32'(o_load_done), 32'(vecs[v].exp_done));
            chk("tbl_error", 32'(o_load_error), 32'(vecs[v].exp_err));
            chk("tbl_writes", 32'(nw), 32'(vecs[v].exp_writes));
        end

        // Start with a byte in the same cycle, and start while busy: both ignored.
        fill_random(2);
        run_load(32'd2, 1'b1, 1'b0, nw);
        chk("startbyte_done", 32'(o_load_done), 32'd1);
        fill_random(1);
        run_load(32'd1, 1'b0, 1'b1, nw);
        chk("midstart_done", 32'(o_load_done), 32'd1);

        // Stalled write: ack after 10 cycles gives 11 stable WRITE cycles.
        ack_delay = 10;
        fill_random(1);
        run_load(32'd1, 1'b0, 1'b0, nw);
        chk("stall_len", 32'(last_len), 32'd11);
        chk("stall_done", 32'(o_load_done), 32'd1);
        ack_delay = 0;

        // No ack at all: timeout after TB_TO write cycles.
        ack_en = 1'b0;
        fill_random(1);
        start_pulse(1'b0);
        send_word(32'd1);
        send_word(tx_words[0]);
        t = 0;
        while (!o_load_error && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 100) bound_fail("timeout_error", t);
        chk("timeout_len", 32'(last_len), 32'(TB_TO));
        chk("timeout_core_rst", 32'(o_core_rst), 32'd1);
        chk("timeout_wr_en", 32'(o_instruction_wr_en), 32'd0);
        chk("timeout_done", 32'(o_load_done), 32'd0);
        ack_en = 1'b1;

        // Reset during the third data byte, then a fresh load.
        start_pulse(1'b0);
        send_word(32'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        i_byte_valid = 1'b1;
        i_byte_data  = 8'h33;
        i_rst        = 1'b1;
        @(negedge i_clk);
        i_rst        = 1'b0;
        i_byte_valid = 1'b0;
        chk("midrst_byte_ready", 32'(o_byte_ready), 32'd0);
        chk("midrst_wr_en", 32'(o_instruction_wr_en), 32'd0);
        chk("midrst_wr_addr", o_instruction_wr_addr, 32'd0);
        chk("midrst_wr_data", o_instruction_wr_data, 32'd0);
        chk("midrst_core_rst", 32'(o_core_rst), 32'd0);
        chk("midrst_busy", 32'(o_load_busy), 32'd0);
        chk("midrst_done", 32'(o_load_done), 32'd0);
        chk("midrst_error", 32'(o_load_error), 32'd0);
        fill_random(2);
        run_load(32'd2, 1'b0, 1'b0, nw);
        chk("postrst_done", 32'(o_load_done), 32'd1);

        // Randomized loads with gaps, variable ack latency and stray acks.
        ack_rnd = 1'b1;
        noise   = 1'b1;
        for (int r = 0; r < 12; r++) begin
            gaps_on = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) hdr = {16'($urandom_range(1, 255)), 16'd1};
            else                           hdr = 32'($urandom_range(0, 6));
            fill_random(int'(hdr[15:0]) > 6 ? 6 : int'(hdr[15:0]));
            run_load(hdr, 1'($urandom_range(0, 1)), 1'b0, nw);
            chk("rnd_done", 32'(o_load_done), 32'((hdr[31:16] == 16'd0) && (hdr[15:0] <= TB_MAX)));
        end
        noise = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_program_loader.md
# rv32i_program_loader

Initiator side of the instruction-memory write port on `RV32I_instruction_fetch_stage` (`i_instruction_wr_en` / `_addr` / `_data` → `o_instruction_wr_valid`). It accepts a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and writes them one at a time into instruction memory starting at `BASE_ADDR`. While a load is in progress it holds the core in reset. It sits beside the core at top level, between the host byte link and the fetch stage.

## Interface
Parameters:
- `BASE_ADDR`, default `32'd0`: first write address; bits [1:0] are ignored (forced to 0).
- `MAX_WORDS`, default `16'd1024`: largest accepted word count.
- `WR_TIMEOUT`, default `16'd255`: cycles to wait for `i_instruction_wr_valid` before error.

Ports:
- `i_clk`  in  1: clock. One clock domain.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_load_start`  in  1: start pulse. Honoured in IDLE, DONE and ERROR; ignored otherwise.
- `i_byte_valid`  in  1: byte stream valid.
- `i_byte_data`  in  8: byte stream data.
- `o_byte_ready`  out  1: loader accepts a byte this cycle.
- `o_instruction_wr_en`  out  1: write request to the fetch stage.
- `o_instruction_wr_addr`  out  32: write address.
- `o_instruction_wr_data`  out  32: write data.
- `i_instruction_wr_valid`  in  1: write acknowledge from the fetch stage.
- `o_core_rst`  out  1: reset/hold for the core.
- `o_load_busy`  out  1: load in progress.
- `o_load_done`  out  1: last load completed; sticky until the next start or reset.
- `o_load_error`  out  1: last load failed; sticky until the next start or reset.

## Operation
- **States:** IDLE, HEADER, DATA, WRITE, DONE, ERROR.
- **Byte transfer:** a byte is transferred on a cycle where `i_byte_valid && o_byte_ready`. `o_byte_ready` = 1 only in HEADER and DATA.
- **IDLE / DONE / ERROR:**
  - On `i_load_start` → HEADER.
  - The start clears done/error, the byte counter, the word index and the header register.
- **HEADER:**
  - Accept 4 bytes, little-endian, forming `word_count[31:0]`. Only bits [15:0] are used; bits [31:16] ≠ 0 is an error.
  - After the 4th byte:
    - count > `MAX_WORDS` or upper bits non-zero → ERROR.
    - count = 0 → DONE.
    - otherwise → DATA.
- **DATA:**
  - Accept 4 bytes into the word assembly register, byte k into bits [8k+7:8k].
  - After the 4th byte → WRITE.
- **WRITE:**
  - `o_instruction_wr_en` = 1.
  - `o_instruction_wr_addr` = `{BASE_ADDR[31:2],2'b00}` + 4·index, 32-bit modulo (wraps silently).
  - `o_instruction_wr_data` = assembled word.
  - Address and data are held stable while in WRITE.
  - On `i_instruction_wr_valid`: index += 1, timeout counter cleared. If index+1 == count → DONE, else → DATA.
  - If the timeout counter reaches `WR_TIMEOUT` without acknowledge → ERROR.
- **`o_core_rst`:** 1 in HEADER, DATA, WRITE and ERROR; 0 in IDLE and DONE.
- **`o_load_busy`:** 1 in HEADER, DATA and WRITE.
- **Counter widths:** 2-bit byte counter; 16-bit word index and timeout counter.

## Timing
- **Reset values:** state IDLE. All outputs 0: `o_byte_ready`, `o_instruction_wr_en`, `o_instruction_wr_addr`, `o_instruction_wr_data`, `o_core_rst`, `o_load_busy`, `o_load_done`, `o_load_error`.
- **Reset mid-load:** returns to IDLE next edge. `o_instruction_wr_en` and `o_core_rst` drop; the partial word is discarded.
- **Start to first byte:** `i_load_start` at edge N puts the loader in HEADER at N+1; `o_byte_ready` = 1 from N+1.
- **Start and byte together:** a byte presented in the same cycle as `i_load_start` is not consumed.
- **Byte to write:** the 4th data byte accepted at edge N gives `o_instruction_wr_en` = 1 from N+1. There is no byte acceptance while in WRITE.
- **Acknowledge:** `i_instruction_wr_valid` sampled at edge M gives `o_instruction_wr_en` = 0 from M+1 (DATA or DONE).
- **Acknowledge in the first cycle:** an acknowledge in the first WRITE cycle is legal, giving a 1-cycle write.
- **`o_instruction_wr_en` behaviour:** it deasserts for at least one cycle between words. The fetch stage leaves LOAD state between words, which is acceptable because the core is held in reset.
- **Throughput:** a gap-free stream gives at best 4 byte cycles + 1 write cycle per word.
- **Acknowledge outside WRITE:** ignored.
- **Start while busy:** ignored (no restart).
- **Timeout:** measured from WRITE entry. ERROR is entered at the cycle the counter equals `WR_TIMEOUT`.

## Structure
- **Shared package `rv32i_pkg`:** add the `loader_state_t` enum and the constant `LOADER_HDR_BYTES = 4`.
- **Sub-module `rv32i_byte_word_assembler`:** natural to split out. It holds the 2-bit counter and 32-bit shift register, with inputs load-byte and clear and output word-complete. The same assembler serves both HEADER and DATA.
- **Top-level connection:** the top ORs `o_core_rst` with system reset into the core, excluding the fetch stage's memory reset.

## Test plan
- **Two-word load:** start, then bytes `02 00 00 00 13 00 00 00 93 00 10 00` with immediate ack. Expect writes (0x0000_0000, 0x0000_0013) then (0x0000_0004, 0x0010_0093), `o_load_done` = 1, `o_core_rst` = 0.
- **Zero count:** header `00 00 00 00`. Expect DONE with no `o_instruction_wr_en` pulse.
- **Oversize count:** with `MAX_WORDS` = 4, header `05 00 00 00`. Expect ERROR, `o_load_error` = 1, `o_core_rst` held at 1, `o_byte_ready` = 0.
- **Stalled write:** ack delayed 10 cycles. Expect address and data stable for all 11 WRITE cycles. With no ack at all and `WR_TIMEOUT` = 8, expect ERROR after 8 cycles.
- **Byte gaps and reset mid-load:** random `i_byte_valid` gaps give the same writes as the gap-free case. `i_rst` during the 3rd data byte gives IDLE and all outputs 0 next cycle; a fresh start then loads correctly.
- **Address alignment:** `BASE_ADDR` = 32'h0000_1002. Expect the first write address to be 0x0000_1000.
